// File: rtl/ic_tester_pkg.sv
// Shared definitions for the IC tester: gate function codes, scan FSM states
// and common timing constants.
package ic_tester_pkg;

  localparam logic [2:0] GATE_AND  = 3'd0;
  localparam logic [2:0] GATE_OR   = 3'd1;
  localparam logic [2:0] GATE_NAND = 3'd2;
  localparam logic [2:0] GATE_NOR  = 3'd3;
  localparam logic [2:0] GATE_XOR  = 3'd4;
  localparam logic [2:0] GATE_XNOR = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_RUN,
    ST_CONFIRM,
    ST_RECORD,
    ST_NEXT,
    ST_FINISH
  } scan_state_t;

  // Cycles per second at the nominal 50 MHz system clock.
  localparam int unsigned ONE_SECOND_DELAY = 50_000_000;

endpackage

// File: rtl/ic_gate_scan_controller_if.sv
// Front-panel and gate-checker signals of the scan controller.
// master = controller side, slave = panel/checker side.
interface ic_gate_scan_controller_if #(parameter int unsigned NUM_GATES = 3);
  logic                 start;
  logic [NUM_GATES-1:0] chk_pass;
  logic [NUM_GATES-1:0] chk_fail;
  logic                 chk_enable;
  logic [2:0]           gate_select;
  logic                 busy;
  logic                 done;
  logic                 ic_found;
  logic [2:0]           ic_type;
  logic [NUM_GATES-1:0] gate_ok;
  logic                 timeout_err;

  modport master (
    input  start, chk_pass, chk_fail,
    output chk_enable, gate_select, busy, done,
    output ic_found, ic_type, gate_ok, timeout_err
  );

  modport slave (
    output start, chk_pass, chk_fail,
    input  chk_enable, gate_select, busy, done,
    input  ic_found, ic_type, gate_ok, timeout_err
  );
endinterface

// File: rtl/ic_gate_scan_controller_edge_detect_rise.sv
// Rising-edge detector for a level input; rise is combinational from the
// registered previous value.
module edge_detect_rise (
  input  logic clk,
  input  logic reset,
  input  logic sig,
  output logic rise
);

  logic sig_q;

  always_ff @(posedge clk) begin
    if (reset) sig_q <= 1'b0;
    else       sig_q <= sig;
  end

  assign rise = sig & ~sig_q;

endmodule

// File: rtl/ic_gate_scan_controller.sv
// Steps the gate checker through every candidate gate function and reports
// which one (if any) makes every gate in the socket pass.
//
// state   | meaning
// IDLE    | waiting for a start edge, results held
// CLEAR   | checker disabled so it drops stale flags
// RUN     | checker enabled, waiting for a complete verdict
// CONFIRM | verdict must stay identical for CONFIRM_CYCLES
// RECORD  | latch the confirmed pass mask
// NEXT    | advance to the next candidate or give up
// FINISH  | one-cycle done pulse
module ic_gate_scan_controller
  import ic_tester_pkg::*;
#(
  parameter int unsigned NUM_GATES      = 3,
  parameter int unsigned NUM_TYPES      = 6,
  parameter int unsigned CLEAR_CYCLES   = 4,
  parameter int unsigned CONFIRM_CYCLES = 16,
  parameter int unsigned TIMEOUT_CYCLES = 500000000
) (
  input logic                    clk,
  input logic                    reset,
  ic_gate_scan_controller_if.master bus
);

  localparam logic [31:0] CLR_LAST  = 32'(CLEAR_CYCLES - 1);
  localparam logic [31:0] CONF_LAST = 32'(CONFIRM_CYCLES - 1);
  localparam logic [31:0] TO_LAST   = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]  CAND_LAST = 3'(NUM_TYPES - 1);

  scan_state_t          state;
  logic [2:0]           cand;
  logic [31:0]          clr_cnt;
  logic [31:0]          to_cnt;
  logic [31:0]          stab_cnt;
  logic [NUM_GATES-1:0] snap;
  logic                 start_rise;
  logic                 complete;
  logic                 timed_out;

  edge_detect_rise u_start_edge (
    .clk   (clk),
    .reset (reset),
    .sig   (bus.start),
    .rise  (start_rise)
  );

  // A gate with both flags raised is still undecided.
  assign complete  = &(bus.chk_pass ^ bus.chk_fail);
  assign timed_out = (to_cnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= ST_IDLE;
      cand            <= '0;
      clr_cnt         <= '0;
      to_cnt          <= '0;
      stab_cnt        <= '0;
      snap            <= '0;
      bus.chk_enable  <= 1'b0;
      bus.gate_select <= '0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.ic_found    <= 1'b0;
      bus.ic_type     <= '0;
      bus.gate_ok     <= '0;
      bus.timeout_err <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start_rise) begin
            state           <= ST_CLEAR;
            cand            <= '0;
            clr_cnt         <= '0;
            bus.gate_select <= '0;
            bus.busy        <= 1'b1;
            bus.chk_enable  <= 1'b0;
            bus.timeout_err <= 1'b0;
            bus.ic_found    <= 1'b0;
            bus.ic_type     <= '0;
            bus.gate_ok     <= '0;
          end
        end
        ST_CLEAR: begin
          clr_cnt <= clr_cnt + 32'd1;
          if (clr_cnt == CLR_LAST) begin
            state          <= ST_RUN;
            to_cnt         <= '0;
            stab_cnt       <= '0;
            bus.chk_enable <= 1'b1;
          end
        end
        ST_RUN, ST_CONFIRM: begin
          to_cnt <= to_cnt + 32'd1;
          if (timed_out) begin
            state           <= ST_NEXT;
            bus.timeout_err <= 1'b1;
            bus.chk_enable  <= 1'b0;
          end else if (state == ST_RUN) begin
            if (complete) begin
              state    <= ST_CONFIRM;
              snap     <= bus.chk_pass;
              stab_cnt <= 32'd1;
            end
          end else if (!complete || bus.chk_pass != snap) begin
            state <= ST_RUN;
          end else begin
            stab_cnt <= stab_cnt + 32'd1;
            if (stab_cnt == CONF_LAST) state <= ST_RECORD;
          end
        end
        ST_RECORD: begin
          bus.gate_ok    <= snap;
          bus.chk_enable <= 1'b0;
          if (&snap) begin
            state        <= ST_FINISH;
            bus.ic_found <= 1'b1;
            bus.ic_type  <= cand;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b1;
          end else begin
            state <= ST_NEXT;
          end
        end
        ST_NEXT: begin
          if (cand == CAND_LAST) begin
            state        <= ST_FINISH;
            bus.ic_found <= 1'b0;
            bus.ic_type  <= '0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b1;
          end else begin
            state           <= ST_CLEAR;
            cand            <= cand + 3'd1;
            bus.gate_select <= cand + 3'd1;
            clr_cnt         <= '0;
          end
        end
        ST_FINISH: begin
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ic_gate_scan_controller.sv
// Directed bench: a behavioural gate checker answers per scenario, a table of
// scenarios gives the expected scan results, plus reset-abort and restart cases.
module tb_ic_gate_scan_controller;

  localparam int D = 3;  // checker latency after enable, cycles

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ic_gate_scan_controller_if #(.NUM_GATES(3)) bus ();

  ic_gate_scan_controller #(
    .NUM_GATES(3), .NUM_TYPES(6), .CLEAR_CYCLES(4),
    .CONFIRM_CYCLES(16), .TIMEOUT_CYCLES(100)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int scen = 0;
  int en_cnt = 0;
  logic [2:0] p, f;

  always @(posedge clk) begin
    if (!bus.chk_enable)  en_cnt <= 0;
    else if (en_cnt < 1000) en_cnt <= en_cnt + 1;
  end

  always_comb begin
    p = 3'b000;
    f = 3'b000;
    if (bus.chk_enable && en_cnt >= D) begin
      case (scen)
        0: if (bus.gate_select == 3'd2) p = 3'b111; else begin p = 3'b011; f = 3'b100; end
        1: begin p = 3'b101; f = 3'b010; end
        2: if (bus.gate_select == 3'd3) begin p = 3'b000; f = 3'b000; end
           else if (bus.gate_select == 3'd4) p = 3'b111;
           else begin p = 3'b001; f = 3'b110; end
        3: if (bus.gate_select == 3'd0 && en_cnt < D + 5) p = 3'b111;
           else begin p = 3'b011; f = 3'b100; end
        4: if (bus.gate_select == 3'd0 && en_cnt < D + 30) begin p = 3'b111; f = 3'b001; end
           else if (bus.gate_select == 3'd1) p = 3'b111;
           else begin p = 3'b011; f = 3'b100; end
        default: ;
      endcase
    end
  end

  assign bus.chk_pass = p;
  assign bus.chk_fail = f;

  // Monitor samples mid-cycle, away from both edges the stimulus uses.
  logic [5:0] visited = '0;
  int done_cnt = 0;
  bit mon_clr = 1'b0;
  always begin
    @(posedge clk);
    #2;
    if (mon_clr) begin
      visited  = '0;
      done_cnt = 0;
    end else begin
      if (bus.chk_enable) visited[bus.gate_select] = 1'b1;
      if (bus.done) done_cnt++;
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    int         sc;
    logic       found;
    logic [2:0] typ;
    logic [2:0] ok;
    logic       to;
    logic [5:0] vis;
  } vec_t;

  vec_t vecs[5];

  task automatic clear_mon();
    @(negedge clk);
    mon_clr = 1'b1;
    @(negedge clk);
    mon_clr = 1'b0;
  endtask

  task automatic run_scan(input vec_t v);
    int i;
    scen = v.sc;
    bus.start = 1'b0;
    clear_mon();
    @(negedge clk);
    bus.start = 1'b1;
    i = 0;
    while (i < 5000 && done_cnt == 0) begin
      @(negedge clk);
      // Re-trigger start mid-scan; must be ignored.
      if (i == 20) bus.start = 1'b0;
      if (i == 22) bus.start = 1'b1;
      i++;
    end
    chk($sformatf("sc%0d done_seen", v.sc), 32'(done_cnt > 0), 32'd1);
    repeat (6) @(negedge clk);
    chk($sformatf("sc%0d done_pulses", v.sc), 32'(done_cnt), 32'd1);
    chk($sformatf("sc%0d busy_after", v.sc), 32'(bus.busy), 32'd0);
    chk($sformatf("sc%0d ic_found", v.sc), 32'(bus.ic_found), 32'(v.found));
    chk($sformatf("sc%0d ic_type", v.sc), 32'(bus.ic_type), 32'(v.typ));
    chk($sformatf("sc%0d gate_ok", v.sc), 32'(bus.gate_ok), 32'(v.ok));
    chk($sformatf("sc%0d timeout_err", v.sc), 32'(bus.timeout_err), 32'(v.to));
    chk($sformatf("sc%0d visited", v.sc), 32'(visited), 32'(v.vis));
    bus.start = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, " outputs"},
        32'({bus.chk_enable, bus.gate_select, bus.busy, bus.done,
             bus.ic_found, bus.ic_type, bus.gate_ok, bus.timeout_err}),
        32'd0);
  endtask

  initial begin
    int i;
    vecs[0] = '{sc: 0, found: 1'b1, typ: 3'd2, ok: 3'b111, to: 1'b0, vis: 6'b000111};
    vecs[1] = '{sc: 1, found: 1'b0, typ: 3'd0, ok: 3'b101, to: 1'b0, vis: 6'b111111};
    vecs[2] = '{sc: 2, found: 1'b1, typ: 3'd4, ok: 3'b111, to: 1'b1, vis: 6'b011111};
    vecs[3] = '{sc: 3, found: 1'b0, typ: 3'd0, ok: 3'b011, to: 1'b0, vis: 6'b111111};
    vecs[4] = '{sc: 4, found: 1'b1, typ: 3'd1, ok: 3'b111, to: 1'b0, vis: 6'b000011};

    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("idle");

    for (int k = 0; k < 5; k++) run_scan(vecs[k]);

    // Reset while cand 2 is in RUN aborts the scan.
    scen = 1;
    clear_mon();
    bus.start = 1'b1;
    i = 0;
    while (i < 2000 && !(bus.chk_enable && bus.gate_select == 3'd2)) begin
      @(negedge clk);
      i++;
    end
    chk("reached_cand2_run", 32'(bus.chk_enable && bus.gate_select == 3'd2), 32'd1);
    bus.start = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check_all_zero("midscan_reset");
    reset = 1'b0;
    repeat (10) @(negedge clk);
    chk("post_reset_busy", 32'(bus.busy), 32'd0);
    chk("post_reset_done", 32'(done_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ic_gate_scan_controller.md
Name: ic_gate_scan_controller

Overview:
- Sequences a gate checker (two- or three-input) through every candidate gate function to identify the IC in the socket automatically.
- Per candidate: drives gate_select, pulses the checker's enable, waits for a stable per-gate verdict, then records the result.
- Sits between the front-panel start/mode controls and the checker. Reports the identified gate type, the per-gate verdict mask and any timeout.

Parameters:
NUM_GATES, 3, gates per IC package checked in parallel; verdict vector width
NUM_TYPES, 6, candidate gate functions scanned, codes 0..NUM_TYPES-1 (AND, OR, NAND, NOR, XOR, XNOR)
CLEAR_CYCLES, 4, cycles chk_enable is held low before each candidate so the checker clears its flags
CONFIRM_CYCLES, 16, consecutive cycles the verdict must stay unchanged and complete before it is sampled
TIMEOUT_CYCLES, 500000000, cycles in RUN without a complete verdict before the candidate is abandoned

Ports:
clk  input  1  system clock
reset  input  1  synchronous active-high reset
start  input  1  level; a rising edge while idle begins a scan
chk_pass  input  NUM_GATES  per-gate pass flags from checker
chk_fail  input  NUM_GATES  per-gate fail flags from checker
chk_enable  output  1  enable to checker
gate_select  output  3  candidate gate code to checker mux
busy  output  1  scan in progress
done  output  1  one-cycle pulse at scan end
ic_found  output  1  held: last scan matched a type
ic_type  output  3  held: matched code (0 if none)
gate_ok  output  NUM_GATES  held: pass mask of the matched type, or of the last candidate if none matched
timeout_err  output  1  held: any candidate timed out in last scan

Behaviour:
- One clock domain (clk); reset is synchronous and active-high.
- Reset values: all outputs 0; state IDLE; all counters 0; start edge register 0.
- Reset mid-scan aborts immediately; same values as above next cycle.
- Start detection: registered start_q; rise = start & ~start_q. Edges during non-IDLE are ignored and not queued.
- Verdict complete: every bit of (chk_pass ^ chk_fail) is 1. A gate with both flags set is incomplete.
- IDLE: chk_enable=0, busy=0. On rise -> CLEAR with cand=0, timeout_err<=0, ic_found<=0, ic_type<=0, gate_ok<=0.
- CLEAR: chk_enable=0, gate_select=cand, busy=1. After CLEAR_CYCLES cycles -> RUN, counters zeroed.
- RUN: chk_enable=1, gate_select=cand. Timeout counter increments each cycle.
  - Verdict complete -> CONFIRM; snapshot chk_pass into snap; stable counter=1.
  - Counter reaches TIMEOUT_CYCLES-1 first -> timeout_err<=1, treat candidate as failed, -> NEXT.
- CONFIRM: chk_enable=1; timeout counter continues.
  - Verdict incomplete or chk_pass != snap -> back to RUN (timeout counter not reset).
  - Otherwise stable counter increments; at CONFIRM_CYCLES -> RECORD.
  - Timeout while in CONFIRM is handled exactly as in RUN.
- RECORD (1 cycle, chk_enable=1): gate_ok<=snap.
  - If snap all ones: ic_found<=1, ic_type<=cand, -> FINISH.
  - Else -> NEXT.
- NEXT (1 cycle, chk_enable=0):
  - If cand==NUM_TYPES-1 -> FINISH with ic_found=0 and ic_type=0.
  - Else cand<=cand+1 -> CLEAR.
  - cand never wraps.
- FINISH: done=1 for exactly one cycle, chk_enable=0, busy=0, -> IDLE. Result outputs hold until the next scan starts.
- Latency, best case per candidate: CLEAR_CYCLES + time to first complete verdict + CONFIRM_CYCLES + 2.
- Counters: 32-bit unsigned, saturate-free because they are reset on each state entry as stated.
- gate_select is a registered output and changes only on entry to CLEAR.

Decomposition:
- Shared package ic_tester_pkg:
  - gate code constants GATE_AND=0, GATE_OR=1, GATE_NAND=2, GATE_NOR=3, GATE_XOR=4, GATE_XNOR=5
  - state encoding constants
  - ONE_SECOND_DELAY
- One sub-module: edge_detect_rise (start edge). The rest stays in one module.

Test Plan:
- Checker model passes all 3 gates only when gate_select==2, with CONFIRM=16 and CLEAR=4 -> codes 0,1,2 visited; ic_found=1, ic_type=2, gate_ok=3'b111; done pulses once; busy low after.
- Model never passes all gates; gate 1 fails for every type -> all 6 candidates visited; ic_found=0, ic_type=0, gate_ok=3'b101; timeout_err=0.
- Model gives no flags for cand 3 (TIMEOUT=100) and all-pass at cand 4 -> timeout_err=1, ic_found=1, ic_type=4.
- Verdict toggles within CONFIRM window (chk_pass 111 -> 011 after 5 cycles, then stable) -> returns to RUN; gate_ok reflects stable value; no early RECORD.
- reset asserted during RUN of cand 2 -> next cycle all outputs 0, chk_enable=0; a start edge during busy is ignored (no restart observed).
- chk_pass and chk_fail both set on one gate -> treated as incomplete; no CONFIRM entry until resolved.
